fetch_decode_buffer: RTL and testbench

//  Fetch->decode boundary: small instruction FIFO between instruction-memory response and decoder.

---
 rtl/fetch_decode_buffer_pkg.sv | 25 ++
 rtl/fetch_decode_buffer_fifo.sv | 50 +++++
 rtl/fetch_decode_buffer.sv | 89 ++++++++
 tb/tb_fetch_decode_buffer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_buffer_pkg.sv
// Shared fetch/decode types and the fetch buffer entry payload.
package GENERAL_DEFS;
    localparam int unsigned WORD = 32;
    typedef logic [31:0] instruction;
    typedef enum logic {
        NO_FLUSH       = 1'b0,
        FLUSH_PIPELINE = 1'b1
    } flush_pipeline_sig;
endpackage

package fetch_decode_buffer_pkg;
    import GENERAL_DEFS::*;

    typedef struct packed {
        instruction           instr;
        logic [WORD-1:0]      pc;
    } fetch_entry_t;

    // Saturating 32-bit accumulate used by the performance counters.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction
endpackage

// File: rtl/fetch_decode_buffer_fifo.sv
// Circular instruction FIFO: storage, read/write pointers, occupancy count.
module fetch_buffer_fifo
    import GENERAL_DEFS::*;
    import fetch_decode_buffer_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             push_i,
    input  fetch_entry_t     wdata_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output fetch_entry_t     rdata_o,
    output logic [CNT_W-1:0] count_o
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Clear drops occupancy only; stale storage is unreachable once rd_ptr catches wr_ptr.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_o <= '0;
        end else if (clear_i) begin
            rd_ptr  <= wr_ptr;
            count_o <= '0;
        end else begin
            if (push_i) begin
                mem[wr_ptr] <= wdata_i;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_i) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_o <= count_o + CNT_W'(1);
                2'b01:   count_o <= count_o - CNT_W'(1);
                default: count_o <= count_o;
            endcase
        end
    end

    assign rdata_o = mem[rd_ptr];

endmodule

// File: rtl/fetch_decode_buffer.sv
// Fetch->decode instruction buffer with epoch-based stale-response filtering.
// Optional FETCH_BUF_PERF_CNT_EN adds saturating stall/drop counters.
module fetch_decode_buffer
    import GENERAL_DEFS::*;
    import fetch_decode_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              fetch_valid_i,
    input  instruction        fetch_instr_i,
    input  logic [WORD-1:0]   fetch_pc_i,
    input  logic              fetch_epoch_i,
    output logic              fetch_ready_o,
    output logic              fetch_epoch_o,
    input  logic              stall_i,
    input  flush_pipeline_sig flush_pipeline_i,
    output logic              is_valid_o,
    output instruction        instruction_o,
    output logic [WORD-1:0]   program_counter_o
`ifdef FETCH_BUF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt_o,
    output logic [31:0]       perf_drop_cnt_o
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic             flush_c;
    logic             epoch_match_c;
    logic             push_c;
    logic             pop_c;
    logic [CNT_W-1:0] count;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;

    assign flush_c       = (flush_pipeline_i == FLUSH_PIPELINE);
    assign epoch_match_c = (fetch_epoch_i == fetch_epoch_o);

    // Ready and valid are pure functions of occupancy, so stall never reaches fetch_ready_o.
    assign fetch_ready_o = (count != CNT_W'(DEPTH));
    assign is_valid_o    = (count != '0);

    assign push_c = fetch_valid_i & fetch_ready_o & epoch_match_c & ~flush_c;
    assign pop_c  = is_valid_o & ~stall_i & ~flush_c;

    assign wr_entry.instr = fetch_instr_i;
    assign wr_entry.pc    = fetch_pc_i;

    fetch_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (push_c),
        .wdata_i   (wr_entry),
        .pop_i     (pop_c),
        .clear_i   (flush_c),
        .rdata_o   (head),
        .count_o   (count)
    );

    assign instruction_o     = head.instr;
    assign program_counter_o = head.pc;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)   fetch_epoch_o <= 1'b0;
        else if (flush_c) fetch_epoch_o <= ~fetch_epoch_o;
    end

`ifdef FETCH_BUF_PERF_CNT_EN
    logic [31:0] drop_inc_c;

    // Drops are stale responses plus whatever occupancy a flush throws away.
    assign drop_inc_c = 32'(fetch_valid_i & ~epoch_match_c) + (flush_c ? 32'(count) : 32'd0);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            perf_stall_cnt_o <= '0;
            perf_drop_cnt_o  <= '0;
        end else begin
            perf_stall_cnt_o <= sat_add32(perf_stall_cnt_o, 32'(is_valid_o & stall_i));
            perf_drop_cnt_o  <= sat_add32(perf_drop_cnt_o, drop_inc_c);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed table-driven bench for fetch_decode_buffer (DEPTH=2), plus reset/perf corner sequences.
module tb_fetch_decode_buffer;
    import GENERAL_DEFS::*;

    logic              clk_i = 1'b0;
    logic              reset_n_i;
    logic              fetch_valid_i;
    instruction        fetch_instr_i;
    logic [WORD-1:0]   fetch_pc_i;
    logic              fetch_epoch_i;
    logic              fetch_ready_o;
    logic              fetch_epoch_o;
    logic              stall_i;
    flush_pipeline_sig flush_pipeline_i;
    logic              is_valid_o;
    instruction        instruction_o;
    logic [WORD-1:0]   program_counter_o;
`ifdef FETCH_BUF_PERF_CNT_EN
    logic [31:0]       perf_stall_cnt_o;
    logic [31:0]       perf_drop_cnt_o;
`endif

    fetch_decode_buffer #(.DEPTH(2)) dut (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .fetch_valid_i     (fetch_valid_i),
        .fetch_instr_i     (fetch_instr_i),
        .fetch_pc_i        (fetch_pc_i),
        .fetch_epoch_i     (fetch_epoch_i),
        .fetch_ready_o     (fetch_ready_o),
        .fetch_epoch_o     (fetch_epoch_o),
        .stall_i           (stall_i),
        .flush_pipeline_i  (flush_pipeline_i),
        .is_valid_o        (is_valid_o),
        .instruction_o     (instruction_o),
        .program_counter_o (program_counter_o)
`ifdef FETCH_BUF_PERF_CNT_EN
        ,
        .perf_stall_cnt_o  (perf_stall_cnt_o),
        .perf_drop_cnt_o   (perf_drop_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        fv;
        logic [31:0] pc;
        logic        ep;
        logic        st;
        logic        fl;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_ready;
        logic        e_epoch;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h1357_9BDF;
    endfunction

    task automatic add(input logic fv, input logic [31:0] pc, input logic ep, input logic st,
                       input logic fl, input logic e_valid, input logic [31:0] e_pc,
                       input logic e_ready, input logic e_epoch);
        vec_t v;
        v.fv = fv; v.pc = pc; v.ep = ep; v.st = st; v.fl = fl;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_ready = e_ready; v.e_epoch = e_epoch;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else passed++;
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc, input logic ep,
                         input logic st, input logic fl);
        fetch_valid_i    = fv;
        fetch_pc_i       = pc;
        fetch_instr_i    = instr_of(pc);
        fetch_epoch_i    = ep;
        stall_i          = st;
        flush_pipeline_i = fl ? FLUSH_PIPELINE : NO_FLUSH;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_n_i = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // fv  pc         ep st fl | valid pc        ready epoch
        add(1, 32'h00, 0, 0, 0,  1, 32'h00, 1, 0);
        add(1, 32'h04, 0, 0, 0,  1, 32'h04, 1, 0);
        add(1, 32'h08, 0, 0, 0,  1, 32'h08, 1, 0);
        add(0, 32'h00, 0, 0, 0,  0, 32'h00, 1, 0);
        add(1, 32'h10, 0, 1, 0,  1, 32'h10, 1, 0);
        add(1, 32'h14, 0, 1, 0,  1, 32'h10, 0, 0);
        add(0, 32'h00, 0, 0, 0,  1, 32'h14, 1, 0);
        add(0, 32'h00, 0, 0, 0,  0, 32'h00, 1, 0);
        add(1, 32'h18, 0, 1, 0,  1, 32'h18, 1, 0);
        add(1, 32'h1C, 0, 1, 0,  1, 32'h18, 0, 0);
        add(1, 32'h24, 0, 1, 1,  0, 32'h00, 1, 1);
        add(1, 32'h20, 0, 0, 0,  0, 32'h00, 1, 1);
        add(1, 32'h40, 1, 0, 0,  1, 32'h40, 1, 1);
        for (int i = 0; i < 10; i++)
            add(1, 32'h44 + 32'(4 * i), 1, 0, 0,  1, 32'h44 + 32'(4 * i), 1, 1);
        add(0, 32'h00, 1, 0, 0,  0, 32'h00, 1, 1);
        add(1, 32'h80, 1, 1, 0,  1, 32'h80, 1, 1);
        add(0, 32'h00, 1, 1, 1,  0, 32'h00, 1, 0);
        add(0, 32'h00, 0, 0, 1,  0, 32'h00, 1, 1);
        add(0, 32'h00, 0, 0, 1,  0, 32'h00, 1, 0);
        add(1, 32'h84, 0, 0, 0,  1, 32'h84, 1, 0);
        add(0, 32'h00, 0, 0, 0,  0, 32'h00, 1, 0);

        #12;
        check("reset_valid", 32'(is_valid_o), 32'd0);
        check("reset_instr", instruction_o, 32'd0);
        check("reset_pc", program_counter_o, 32'd0);
        check("reset_ready", 32'(fetch_ready_o), 32'd1);
        check("reset_epoch", 32'(fetch_epoch_o), 32'd0);
        reset_n_i = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].fv, vecs[k].pc, vecs[k].ep, vecs[k].st, vecs[k].fl);
            step();
            check($sformatf("v%0d_valid", k), 32'(is_valid_o), 32'(vecs[k].e_valid));
            check($sformatf("v%0d_ready", k), 32'(fetch_ready_o), 32'(vecs[k].e_ready));
            check($sformatf("v%0d_epoch", k), 32'(fetch_epoch_o), 32'(vecs[k].e_epoch));
            if (vecs[k].e_valid) begin
                check($sformatf("v%0d_pc", k), program_counter_o, vecs[k].e_pc);
                check($sformatf("v%0d_instr", k), instruction_o, instr_of(vecs[k].e_pc));
            end
        end

        // Asynchronous reset with two entries held under stall.
        drive(1'b1, 32'h90, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'h94, 1'b0, 1'b1, 1'b0);
        step();
        check("full_before_rst_valid", 32'(is_valid_o), 32'd1);
        check("full_before_rst_ready", 32'(fetch_ready_o), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        #2;
        reset_n_i = 1'b0;
        #1;
        check("async_rst_valid", 32'(is_valid_o), 32'd0);
        check("async_rst_pc", program_counter_o, 32'd0);
        check("async_rst_instr", instruction_o, 32'd0);
        check("async_rst_ready", 32'(fetch_ready_o), 32'd1);
        check("async_rst_epoch", 32'(fetch_epoch_o), 32'd0);
        step();
        check("rst_held_valid", 32'(is_valid_o), 32'd0);
        reset_n_i = 1'b1;

`ifdef FETCH_BUF_PERF_CNT_EN
        check("perf_stall_reset", perf_stall_cnt_o, 32'd0);
        check("perf_drop_reset", perf_drop_cnt_o, 32'd0);
        drive(1'b1, 32'hA0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step();
        check("perf_stall_5", perf_stall_cnt_o, 32'd5);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("perf_stall_hold", perf_stall_cnt_o, 32'd5);
        check("perf_pop_valid", 32'(is_valid_o), 32'd0);
        drive(1'b1, 32'hB0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'hB4, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'hB8, 1'b1, 1'b1, 1'b1);
        step();
        check("perf_drop_flush", perf_drop_cnt_o, 32'd3);
        check("perf_stall_flush", perf_stall_cnt_o, 32'd7);
        check("perf_flush_valid", 32'(is_valid_o), 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
